ram_dma_arbiter: RTL and testbench

Shares the single-port 56 kB RAM between the tv80 CPU and one DMA requester, such as a UART boot loader or a block-copy engine. It obtains the bus through the Z80 nBUSRQ/nBUSAK handshake and multiplexes the RAM control, address and data pins. It runs bursts of bounded length, then returns the bus to the CPU. It sits between the CPU memory decode and the RAM macro, on the CPU clock.

---
 rtl/ram_dma_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_dma_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dma_arbiter.sv
// ram_dma_arbiter
//   Shares the single-port RAM between the tv80 CPU and one DMA requester.
//   The bus is obtained with the Z80 busrq_n/busak_n handshake. Bursts are
//   bounded to MAX_BURST beats, and then the bus is handed back to the CPU.
//   The RAM control, address and data pins are multiplexed combinationally.
//
// Ports
//   clk, aresetn            CPU clock; asynchronous active-low reset
//   cpu_busrq_n/busak_n     bus request to / acknowledge from the tv80
//   cpu_ramrd/ramwr/addr/dout  CPU-side RAM access
//   dma_req/we/last/addr/wdata  DMA beat request
//   dma_gnt/ack             bus owned by DMA / beat accepted this cycle
//   dma_rdata/rvalid        read return, one cycle after the read beat
//   dma_err                 one-cycle pulse on bus-acknowledge timeout
//   ram_ce/wre/ad/din/dout  RAM macro pins (ram_dout has 1-cycle latency)
//
// Build option
//   ARB_TIMEOUT_EN  when defined, REQ gives up after ACK_TIMEOUT cycles
//                   without busak_n, pulses dma_err and releases the bus.
module ram_dma_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int MAX_BURST   = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              aresetn,
  output logic              cpu_busrq_n,
  input  logic              cpu_busak_n,
  input  logic              cpu_ramrd,
  input  logic              cpu_ramwr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_last,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  output logic              dma_rvalid,
  output logic              dma_err,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  typedef enum logic [2:0] {IDLE, REQ, GRANT, DRAIN, RELEASE} state_t;

`ifdef ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam logic [7:0] MaxBurst   = 8'(MAX_BURST);
  localparam logic [7:0] AckTimeout = 8'(ACK_TIMEOUT);

  state_t     state, nextState;
  logic [7:0] beatCnt;
  logic [7:0] reqCnt;
  logic [7:0] rdataHold;
  logic       beat;
  logic       burstEnd;
  logic       timeout;
  logic       retryBlock;

  assign beat     = (state == GRANT) && dma_req;
  assign burstEnd = beat && (dma_last || (beatCnt == MaxBurst - 8'd1));
  assign timeout  = TimeoutEn && (state == REQ) && cpu_busak_n && (reqCnt == AckTimeout);

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (dma_req && !retryBlock) nextState = REQ;
      REQ: begin
        if (!cpu_busak_n)  nextState = GRANT;
        else if (!dma_req) nextState = RELEASE;
        else if (timeout)  nextState = RELEASE;
      end
      GRANT:   if (!dma_req || burstEnd) nextState = DRAIN;
      DRAIN:   nextState = RELEASE;
      RELEASE: if (cpu_busak_n) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs and RAM pin multiplexer
  always_comb begin
    cpu_busrq_n = 1'b1;
    dma_gnt     = 1'b0;
    dma_ack     = 1'b0;
    dma_err     = 1'b0;
    ram_ce      = cpu_ramrd | cpu_ramwr;
    ram_wre     = cpu_ramwr;
    ram_ad      = cpu_addr;
    ram_din     = cpu_dout;
    case (state)
      REQ: begin
        cpu_busrq_n = 1'b0;
        dma_err     = timeout;
      end
      GRANT: begin
        cpu_busrq_n = 1'b0;
        dma_gnt     = 1'b1;
        dma_ack     = dma_req;
        ram_ce      = dma_req;
        ram_wre     = dma_req & dma_we;
        ram_ad      = dma_addr;
        ram_din     = dma_wdata;
      end
      DRAIN: begin
        // Bus still held so the last read's data can come back.
        cpu_busrq_n = 1'b0;
        ram_ce      = 1'b0;
        ram_wre     = 1'b0;
        ram_ad      = dma_addr;
        ram_din     = dma_wdata;
      end
      default: ;
    endcase
  end

  // Beat counter: held at zero while waiting in REQ so every grant starts
  // from zero; saturates at MAX_BURST.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                         beatCnt <= '0;
    else if (state == REQ)                beatCnt <= '0;
    else if (beat && beatCnt != MaxBurst) beatCnt <= beatCnt + 8'd1;
  end

  // Bus-acknowledge wait counter; only consulted when the timeout is built in.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                 reqCnt <= '0;
    else if (state != REQ)        reqCnt <= '0;
    else if (reqCnt != AckTimeout) reqCnt <= reqCnt + 8'd1;
  end

  // After a timeout the requester must drop dma_req before it can retry.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)      retryBlock <= 1'b0;
    else if (timeout)  retryBlock <= 1'b1;
    else if (!dma_req) retryBlock <= 1'b0;
  end

  // Read return: RAM output is already registered, so the data is passed
  // straight through in the valid cycle and held afterwards.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      dma_rvalid <= 1'b0;
      rdataHold  <= '0;
    end else begin
      dma_rvalid <= beat & ~dma_we;
      if (dma_rvalid) rdataHold <= ram_dout;
    end
  end

  assign dma_rdata = dma_rvalid ? ram_dout : rdataHold;

endmodule

// File: tb/tb_ram_dma_arbiter.sv
module tb_ram_dma_arbiter;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cpu_busrq_n;
  logic        cpu_busak_n = 1'b1;
  logic        cpu_ramrd = 1'b0, cpu_ramwr = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic        dma_gnt, dma_ack, dma_rvalid, dma_err;
  logic [7:0]  dma_rdata;
  logic        ram_ce, ram_wre;
  logic [15:0] ram_ad;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] ramArr [65536];
  logic [7:0] refMem [65536];
  logic [7:0] expQ [$];
  int         grantLens [$];
  bit         busakStuck = 1'b0;
  int         runLen = 0, maxRun = 0;
  int         busrqFallCyc, busakLowCyc, gntRiseCyc, lastAckCyc, releaseCyc, wreCount;

  ram_dma_arbiter #(.ADDR_W(16), .MAX_BURST(16), .ACK_TIMEOUT(10)) dut (
    .clk(clk), .aresetn(aresetn),
    .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
    .cpu_ramrd(cpu_ramrd), .cpu_ramwr(cpu_ramwr),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_err(dma_err),
    .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CPU traffic stays in the upper half so it never touches DMA data.
  task automatic cpuRandom();
    int r;
    r = $urandom_range(0, 3);
    cpu_ramrd = (r == 1);
    cpu_ramwr = (r == 2);
    cpu_addr  = 16'h8000 | 16'($urandom_range(0, 16'h7fff));
    cpu_dout  = 8'($urandom);
  endtask

  task automatic checkCpuMirror(input string tag);
    check({tag, "_ce"},  ram_ce,  cpu_ramrd | cpu_ramwr);
    check({tag, "_wre"}, ram_wre, cpu_ramwr);
    check({tag, "_ad"},  ram_ad,  cpu_addr);
    check({tag, "_din"}, ram_din, cpu_dout);
  endtask

  task automatic idleCycles(input int k);
    repeat (k) begin @(posedge clk); #1; cpuRandom(); end
  endtask

  // RAM macro: registered read, pins sampled before the edge.
  initial begin : ramModel
    logic ce, we;
    logic [15:0] a;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      ce = ram_ce; we = ram_wre; a = ram_ad; d = ram_din;
      @(posedge clk); #1;
      if (ce) begin
        if (we) ramArr[a] = d;
        else    ram_dout = ramArr[a];
      end
    end
  end

  // tv80 bus acknowledge with 0..2 cycles of random latency.
  initial begin : busakModel
    int dly;
    dly = 1;
    forever begin
      @(posedge clk); #1;
      if (busakStuck) cpu_busak_n = 1'b1;
      else if (cpu_busak_n != cpu_busrq_n) begin
        if (dly == 0) begin
          cpu_busak_n = cpu_busrq_n;
          dly = $urandom_range(0, 2);
        end else dly--;
      end
    end
  end

  // Scoreboard monitor for read returns.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (dma_rvalid) begin
        runLen++;
        if (runLen > maxRun) maxRun = runLen;
        if (expQ.size() == 0) check("rvalid_unexpected", dma_rvalid, 1'b0);
        else begin
          e = expQ.pop_front();
          check("rdata", dma_rdata, e);
        end
      end else runLen = 0;
    end
  end

  // Issue n beats of consecutive addresses; gapPct percent of cycles drop
  // dma_req. Returns once the bus is back with the CPU.
  task automatic runStream(input int n, input bit we, input logic [15:0] base,
                           input logic [7:0] d0, input int gapPct);
    int beat, guard, cyc0, curLen, highRun, off;
    bit prevGnt, seenGrant;
    beat = 0; guard = 0; curLen = 0; highRun = 0;
    prevGnt = 1'b0; seenGrant = 1'b0;
    grantLens.delete();
    busrqFallCyc = -1; busakLowCyc = -1; gntRiseCyc = -1;
    lastAckCyc = -1; releaseCyc = -1; wreCount = 0;
    cyc0 = cyc;
    dma_we = we; dma_addr = base; dma_wdata = d0; dma_last = (n == 1); dma_req = 1'b1;
    cpuRandom();
    while (guard < 3000) begin
      @(negedge clk);
      off = cyc - cyc0;
      if (busrqFallCyc < 0 && !cpu_busrq_n) busrqFallCyc = off;
      if (busakLowCyc < 0 && !cpu_busak_n)  busakLowCyc = off;
      if (gntRiseCyc < 0 && dma_gnt)        gntRiseCyc = off;
      check("ack", dma_ack, dma_gnt & dma_req);
      check("err", dma_err, 1'b0);
      if (dma_gnt) begin
        check("g_ce", ram_ce, dma_req);
        if (dma_req) begin
          check("g_wre", ram_wre, dma_we);
          check("g_ad",  ram_ad,  dma_addr);
          check("g_din", ram_din, dma_wdata);
        end
      end else if (prevGnt) begin
        check("drain_ce", ram_ce, 1'b0);
        check("drain_busrq", cpu_busrq_n, 1'b0);
      end else checkCpuMirror("cpu");
      if ((dma_gnt || prevGnt) && ram_wre) wreCount++;
      if (dma_gnt && !prevGnt) begin
        if (seenGrant) check("gap_idle", highRun >= 2, 1'b1);
        seenGrant = 1'b1;
      end
      if (!dma_gnt && prevGnt) begin
        grantLens.push_back(curLen);
        curLen = 0;
        highRun = 0;
      end
      if (cpu_busrq_n) highRun++;
      if (dma_ack) begin
        curLen++;
        if (we) refMem[dma_addr] = dma_wdata;
        else    expQ.push_back(refMem[dma_addr]);
        beat++;
        if (beat == n) lastAckCyc = off;
      end
      if (lastAckCyc >= 0 && releaseCyc < 0 && off > lastAckCyc && cpu_busrq_n) releaseCyc = off;
      prevGnt = dma_gnt;
      if (beat == n && cpu_busrq_n && !dma_gnt) break;
      @(posedge clk); #1;
      guard++;
      cpuRandom();
      if (beat == n) begin
        dma_req = 1'b0;
        dma_last = 1'b0;
      end else begin
        dma_addr  = base + 16'(beat);
        dma_wdata = d0 + 8'(beat);
        dma_last  = (beat == n - 1);
        dma_req   = ($urandom_range(0, 99) >= gapPct);
      end
    end
    check("stream_beats", beat, n);
    @(posedge clk); #1;
    dma_req = 1'b0;
    dma_last = 1'b0;
  endtask

  initial begin : main
    int errCyc, errCnt, off, cyc0;
    bit got;
    for (int i = 0; i < 65536; i++) begin
      ramArr[i] = 8'(i) ^ 8'h5A;
      refMem[i] = 8'(i) ^ 8'h5A;
    end

    // Reset state
    #2;
    check("rst_busrq", cpu_busrq_n, 1'b1);
    check("rst_gnt",   dma_gnt,     1'b0);
    check("rst_ack",   dma_ack,     1'b0);
    check("rst_rvalid", dma_rvalid, 1'b0);
    check("rst_rdata", dma_rdata,   8'h00);
    check("rst_err",   dma_err,     1'b0);
    #21 aresetn = 1'b1;

    // 100 cycles of CPU traffic with no DMA request
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cpuRandom();
      @(negedge clk);
      checkCpuMirror("idle");
      check("idle_busrq", cpu_busrq_n, 1'b1);
      check("idle_gnt", dma_gnt, 1'b0);
    end
    @(posedge clk); #1;

    // 4-beat write burst
    runStream(4, 1'b1, 16'h2000, 8'hA0, 0);
    check("w4_busrq_fall", busrqFallCyc, 1);
    check("w4_gnt_rise", gntRiseCyc, busakLowCyc + 1);
    check("w4_wre_cycles", wreCount, 4);
    check("w4_release", releaseCyc, lastAckCyc + 2);
    check("w4_ngrants", grantLens.size(), 1);
    if (grantLens.size() > 0) check("w4_len", grantLens[0], 4);
    idleCycles(4);

    // 3-beat read of the same addresses
    maxRun = 0;
    runStream(3, 1'b0, 16'h2000, 8'h00, 0);
    idleCycles(2);
    check("r3_run", maxRun, 3);
    check("r3_drained", expQ.size(), 0);
    idleCycles(2);

    // 40 back-to-back beats split by MAX_BURST
    runStream(40, 1'b1, 16'h3000, 8'h10, 0);
    check("b40_ngrants", grantLens.size(), 3);
    if (grantLens.size() == 3) begin
      check("b40_len0", grantLens[0], 16);
      check("b40_len1", grantLens[1], 16);
      check("b40_len2", grantLens[2], 8);
    end
    idleCycles(3);
    runStream(40, 1'b0, 16'h3000, 8'h00, 0);
    idleCycles(3);

    // Randomized streams with request gaps
    for (int i = 0; i < 8; i++) begin
      runStream($urandom_range(1, 20), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 16'h7f00)), 8'($urandom), 20);
      idleCycles($urandom_range(1, 3));
    end
    runStream(20, 1'b0, 16'h3000, 8'h00, 20);
    idleCycles(3);
    check("rand_drained", expQ.size(), 0);

    // Reset asserted in GRANT with a read return in flight
    dma_we = 1'b0; dma_addr = 16'h2001; dma_wdata = '0; dma_last = 1'b0; dma_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (dma_ack) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("mid_got_beat", got, 1'b1);
    @(posedge clk); #2;
    check("mid_pre_rvalid", dma_rvalid, 1'b1);
    check("mid_pre_gnt", dma_gnt, 1'b1);
    aresetn = 1'b0;
    #1;
    check("mid_busrq", cpu_busrq_n, 1'b1);
    check("mid_gnt", dma_gnt, 1'b0);
    check("mid_rvalid", dma_rvalid, 1'b0);
    check("mid_rdata", dma_rdata, 8'h00);
    check("mid_ack", dma_ack, 1'b0);
    checkCpuMirror("mid");
    dma_req = 1'b0;
    @(posedge clk); #3;
    aresetn = 1'b1;
    idleCycles(6);
    check("mid_drained", expQ.size(), 0);

`ifdef ARB_TIMEOUT_EN
    // Bus acknowledge never arrives
    busakStuck = 1'b1;
    idleCycles(4);
    cyc0 = cyc;
    dma_we = 1'b1; dma_addr = 16'h4000; dma_wdata = 8'hEE; dma_last = 1'b1; dma_req = 1'b1;
    errCyc = -1; errCnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      off = cyc - cyc0;
      if (dma_err) begin
        errCnt++;
        if (errCyc < 0) errCyc = off;
      end
      check("to_gnt", dma_gnt, 1'b0);
      check("to_ack", dma_ack, 1'b0);
      if (off >= 1 && off <= 11) check("to_busrq_req", cpu_busrq_n, 1'b0);
      if (off >= 12) check("to_busrq_rel", cpu_busrq_n, 1'b1);
      @(posedge clk); #1;
      cpuRandom();
    end
    check("to_err_cycle", errCyc, 11);
    check("to_err_count", errCnt, 1);
    check("to_no_write", ramArr[16'h4000], refMem[16'h4000]);
    dma_req = 1'b0;
    busakStuck = 1'b0;
    idleCycles(4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
